// File: rtl/serial_pattern_tx_if.sv
// ============================================================================
// Module   : serial_pattern_tx_if
// Brief    : Load handshake and serial output bundle for serial_pattern_tx.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_pattern_tx_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              i_load_valid;
    logic [DATA_W-1:0] i_load_data;
    logic [LEN_W-1:0]  i_load_len;
    logic              o_load_ready;
    logic              o_data_out;
    logic              o_data_vld;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_load_valid, i_load_data, i_load_len,
        input  o_load_ready, o_data_out, o_data_vld, o_busy, o_done
    );

    modport slave (
        input  i_load_valid, i_load_data, i_load_len,
        output o_load_ready, o_data_out, o_data_vld, o_busy, o_done
    );
endinterface

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
// ============================================================================
// Module   : serial_pattern_tx
// Brief    : Parallel-to-serial MSB-first bit-pattern transmitter with idle gap.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_pattern_tx #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 4,
    parameter int GAP_CYCLES = 2,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  wire logic          i_sys_clk,
    input  wire logic          i_rst_n,
    serial_pattern_tx_if.slave bus
);

    localparam int             GAP_W      = $clog2(GAP_CYCLES + 2);
    localparam logic [LEN_W-1:0] c_DATA_LEN = LEN_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              out_q, out_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic              w_accept;
    logic [LEN_W-1:0]  w_len_eff;

    assign w_accept  = bus.i_load_valid & ready_q;
    assign w_len_eff = (bus.i_load_len > c_DATA_LEN) ? c_DATA_LEN : bus.i_load_len;

    // The frame is left-aligned in shreg so the bit on the wire is always the MSB;
    // cnt holds how many bits remain after the one currently presented.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        out_d   = IDLE_LEVEL;
        vld_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_len_eff != '0) begin
                        state_d = ST_SHIFT;
                        shreg_d = bus.i_load_data << (c_DATA_LEN - w_len_eff);
                        cnt_d   = w_len_eff - LEN_W'(1);
                        out_d   = shreg_d[DATA_W-1];
                        vld_d   = 1'b1;
                        done_d  = (w_len_eff == LEN_W'(1));
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - LEN_W'(1);
                    out_d   = shreg_d[DATA_W-1];
                    vld_d   = 1'b1;
                    done_d  = (cnt_q == LEN_W'(1));
                end else begin
                    shreg_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            out_q   <= IDLE_LEVEL;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o_load_ready = ready_q;
    assign bus.o_data_out   = out_q;
    assign bus.o_data_vld   = vld_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
// ============================================================================
// Module   : tb_serial_pattern_tx
// Brief    : Self-checking bench for serial_pattern_tx (GAP_CYCLES 2 and 0).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_pattern_tx;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic [3:0] len;
    logic       sel;          // 0: observe GAP=2 instance, 1: observe GAP=0 instance
    logic [4:0] obs;          // {vld, out, done, busy, ready}
    int         checks;
    int         passes;

    serial_pattern_tx_if #(.DATA_W(8), .LEN_W(4)) bus2 ();
    serial_pattern_tx_if #(.DATA_W(8), .LEN_W(4)) bus0 ();

    assign bus2.i_load_valid = valid;
    assign bus2.i_load_data  = data;
    assign bus2.i_load_len   = len;
    assign bus0.i_load_valid = valid;
    assign bus0.i_load_data  = data;
    assign bus0.i_load_len   = len;

    serial_pattern_tx #(.DATA_W(8), .LEN_W(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_dut (
        .i_sys_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus2)
    );

    serial_pattern_tx #(.DATA_W(8), .LEN_W(4), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut0 (
        .i_sys_clk (clk),
        .i_rst_n   (rst_n),
        .bus       (bus0)
    );

    always_comb begin
        if (sel)
            obs = {bus0.o_data_vld, bus0.o_data_out, bus0.o_done, bus0.o_busy, bus0.o_load_ready};
        else
            obs = {bus2.o_data_vld, bus2.o_data_out, bus2.o_done, bus2.o_busy, bus2.o_load_ready};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (obs[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (obs[0] !== 1'b1)
            $display("FAIL wait_ready: o_load_ready=%b after %0d cycles, required 1", obs[0], n);
        else
            passes++;
    endtask

    // Reference: a frame is the list data[L-1]..data[0] with L=min(len,8), then
    // gap idle-busy cycles, then an idle ready cycle. len 0 is a lone done pulse.
    task automatic send(input logic [7:0] d, input logic [3:0] ln, input bit hold,
                        input logic [7:0] nd, input logic [3:0] nl);
        int         l;
        int         gap;
        logic [4:0] exp;
        l   = (ln > 4'd8) ? 8 : int'(ln);
        gap = sel ? 0 : 2;
        valid = 1'b1;
        data  = d;
        len   = ln;
        @(negedge clk);
        if (hold) begin
            data = nd;
            len  = nl;
        end else begin
            valid = 1'b0;
            data  = 8'($urandom);
            len   = 4'($urandom);
        end
        if (l == 0) begin
            exp = 5'b00101;
            checks++;
            if (obs !== exp)
                $display("FAIL len0_done: got %b required %b", obs, exp);
            else
                passes++;
            return;
        end
        for (int k = 0; k < l; k++) begin
            exp = {1'b1, d[l-1-k], (k == l-1), 1'b1, 1'b0};
            checks++;
            if (obs !== exp)
                $display("FAIL bit%0d (d=%h len=%0d gap=%0d): got %b required %b", k, d, ln, gap, obs, exp);
            else
                passes++;
            @(negedge clk);
        end
        for (int g = 0; g < gap; g++) begin
            exp = 5'b00010;
            checks++;
            if (obs !== exp)
                $display("FAIL gap%0d: got %b required %b", g, obs, exp);
            else
                passes++;
            @(negedge clk);
        end
        exp = 5'b00001;
        checks++;
        if (obs !== exp)
            $display("FAIL frame_end (d=%h len=%0d): got %b required %b", d, ln, obs, exp);
        else
            passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;
        len   = '0;
        sel   = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus2.o_data_vld, bus2.o_data_out, bus2.o_done, bus2.o_busy, bus2.o_load_ready} !== 5'b00001)
            $display("FAIL reset_gap2: got %b required 00001",
                     {bus2.o_data_vld, bus2.o_data_out, bus2.o_done, bus2.o_busy, bus2.o_load_ready});
        else
            passes++;
        checks++;
        if ({bus0.o_data_vld, bus0.o_data_out, bus0.o_done, bus0.o_busy, bus0.o_load_ready} !== 5'b00001)
            $display("FAIL reset_gap0: got %b required 00001",
                     {bus0.o_data_vld, bus0.o_data_out, bus0.o_done, bus0.o_busy, bus0.o_load_ready});
        else
            passes++;
    endtask

    task automatic test_directed();
        sel = 1'b0;
        wait_ready();
        send(8'hA6, 4'd8, 1'b0, 8'h00, 4'd0);
        send(8'h05, 4'd3, 1'b0, 8'h00, 4'd0);
        send(8'h3C, 4'd0, 1'b0, 8'h00, 4'd0);
        @(negedge clk);
        checks++;
        if (obs !== 5'b00001)
            $display("FAIL len0_after: got %b required 00001", obs);
        else
            passes++;
        send(8'hC3, 4'd12, 1'b0, 8'h00, 4'd0);
        send(8'h01, 4'd1, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        wait_ready();
        send(8'h9B, 4'd5, 1'b1, 8'h6D, 4'd7);
        send(8'h6D, 4'd7, 1'b1, 8'hF0, 4'd15);
        send(8'hF0, 4'd15, 1'b0, 8'h00, 4'd0);
        sel = 1'b0;
        wait_ready();
        send(8'h5A, 4'd6, 1'b1, 8'hE7, 4'd8);
        send(8'hE7, 4'd8, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        wait_ready();
        valid = 1'b1;
        data  = 8'hFF;
        len   = 4'd8;
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus2.o_data_vld, bus2.o_data_out, bus2.o_done, bus2.o_busy, bus2.o_load_ready} !== 5'b00001)
            $display("FAIL async_reset: got %b required 00001",
                     {bus2.o_data_vld, bus2.o_data_out, bus2.o_done, bus2.o_busy, bus2.o_load_ready});
        else
            passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b00001)
                $display("FAIL post_reset%0d: got %b required 00001", k, obs);
            else
                passes++;
        end
        send(8'h69, 4'd8, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic test_detector();
        logic [3:0] hist;
        int         hit;
        sel  = 1'b0;
        hist = '0;
        hit  = -1;
        wait_ready();
        valid = 1'b1;
        data  = 8'h05;
        len   = 4'd4;
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (obs[4] === 1'b1) begin
                hist = {hist[2:0], obs[3]};
                if (hist == 4'b0101 && hit < 0 && obs[2] === 1'b1)
                    hit = k;
            end
            @(negedge clk);
        end
        checks++;
        if (hit !== 3)
            $display("FAIL detect_0101: hit cycle %0d required 3 (stream %b)", hit, hist);
        else
            passes++;
        wait_ready();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [3:0] ln;
        for (int i = 0; i < 30; i++) begin
            sel = 1'($urandom);
            #1;
            wait_ready();
            d  = 8'($urandom);
            ln = 4'($urandom_range(0, 15));
            send(d, ln, 1'b0, 8'h00, 4'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_detector();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
